// File: rtl/alu_seq_ctrl_if.sv
// Bundle of the instruction handshake, ALU drive/return, completion and debug-read signals.
// No logic of its own; timing is set by whoever drives each side.
// in_valid/in_ready handshake; the source must hold in_valid until in_ready is seen.
interface alu_seq_ctrl_if #(parameter int N = 8);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic         in_sign;
  logic [1:0]   in_rd;
  logic [1:0]   in_rs1;
  logic [1:0]   in_rs2;
  logic [N-1:0] in_imm;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_op;
  logic         alu_sign;
  logic [N-1:0] alu_result;
  logic         out_valid;
  logic [N-1:0] out_result;
  logic         out_err;
  logic [1:0]   dbg_addr;
  logic [N-1:0] dbg_data;

  // Sequencer side.
  modport slave (
    input  in_valid, in_op, in_sign, in_rd, in_rs1, in_rs2, in_imm, alu_result, dbg_addr,
    output in_ready, alu_a, alu_b, alu_op, alu_sign, out_valid, out_result, out_err, dbg_data
  );

  // Instruction source, ALU and debug reader side.
  modport master (
    output in_valid, in_op, in_sign, in_rd, in_rs1, in_rs2, in_imm, alu_result, dbg_addr,
    input  in_ready, alu_a, alu_b, alu_op, alu_sign, out_valid, out_result, out_err, dbg_data
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequences one instruction at a time through the external ALU and a 4-entry register file.
// Accept at edge k -> out_valid high in the cycle after edge k+2; one instruction per 3 cycles.
// in_ready is high only in IDLE; in_valid outside IDLE is ignored and must be held by the source.
module alu_seq_ctrl #(
  parameter int N = 8
) (
  input logic          clk,
  input logic          rst,
  alu_seq_ctrl_if.slave bus
);

  localparam logic [3:0] OP_LDI = 4'b1111;
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t       state;
  state_t       state_n;

  logic [N-1:0] rf [4];
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_op;
  logic         alu_sign;
  logic [1:0]   rd;
  logic [N-1:0] imm;
  logic [N-1:0] res;
  logic         err;
  logic         out_valid;
  logic [N-1:0] out_result;
  logic         out_err;
  logic         accept;

  assign bus.in_ready = (state == IDLE);
  assign accept       = bus.in_valid && (state == IDLE);

  // State register; reset drops any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state: EXEC and WB each last exactly one cycle.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_n = EXEC;
      EXEC:    state_n = WB;
      WB:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: operand fetch at accept, result capture in EXEC, write-back and completion out of WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_sign   <= 1'b0;
      rd         <= '0;
      imm        <= '0;
      res        <= '0;
      err        <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_err    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        // rf is read here, after any earlier write-back has committed, so no forwarding is needed.
        alu_a    <= rf[bus.in_rs1];
        alu_b    <= rf[bus.in_rs2];
        alu_op   <= bus.in_op;
        alu_sign <= bus.in_sign;
        rd       <= bus.in_rd;
        imm      <= bus.in_imm;
      end
      if (state == EXEC) begin
        res <= (alu_op == OP_LDI) ? imm : bus.alu_result;
        err <= (alu_op == OP_DIV) && (alu_b == '0);
      end
      if (state == WB) begin
        if (!err) rf[rd] <= res;
        out_valid  <= 1'b1;
        out_result <= err ? '0 : res;
        out_err    <= err;
      end
    end
  end

  assign bus.alu_a      = alu_a;
  assign bus.alu_b      = alu_b;
  assign bus.alu_op     = alu_op;
  assign bus.alu_sign   = alu_sign;
  assign bus.out_valid  = out_valid;
  assign bus.out_result = out_result;
  assign bus.out_err    = out_err;
  assign bus.dbg_data   = rf[bus.dbg_addr];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized scoreboard bench for alu_seq_ctrl with a behavioural ALU and register-file model.
// Stimulus pushes expected completions; a negedge monitor pops and compares on out_valid.
// Exercises backpressure by holding in_valid high across EXEC/WB.
module tb_alu_seq_ctrl;
  localparam int N = 8;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  alu_seq_ctrl_if #(.N(N)) bus ();

  alu_seq_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N-1:0] res;
    logic         err;
    int           acc;
  } exp_t;

  exp_t         q[$];
  logic [N-1:0] rf_m [4];
  logic [N-1:0] e_a;
  logic [N-1:0] e_b;
  logic [3:0]   e_op;
  logic         e_sign;
  int           acc_g;

  // Clock: 20-unit period.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Edge counter used for latency checks.
  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  // Behavioural stand-in for the external combinational ALU.
  function automatic logic [N-1:0] alu_f(logic [N-1:0] a, logic [N-1:0] b, logic [3:0] op, logic sgn);
    logic signed [N-1:0] sa;
    logic signed [N-1:0] sb;
    logic signed [N-1:0] sq;
    sa = a;
    sb = b;
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: begin
        if (b == '0) return '0;
        if (sgn) begin
          sq = sa / sb;
          return sq;
        end
        return a / b;
      end
      4'h4: return a | b;
      4'h5: return a ^ b;
      default: return '1;
    endcase
  endfunction

  always_comb bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_sign);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per completion, checks pulse width, latency and held outputs.
  initial begin
    logic [N-1:0] held_res;
    logic         held_err;
    logic         prev_vld;
    exp_t         e;
    held_res = '0;
    held_err = 1'b0;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_res = '0;
        held_err = 1'b0;
        prev_vld = 1'b0;
      end else begin
        if (bus.out_valid) begin
          chk("out_valid_single_cycle", {31'b0, prev_vld}, 32'd0);
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out_valid actual=1 expected=0 (t=%0t)", $time);
          end else begin
            e = q.pop_front();
            chk("out_result", {24'b0, bus.out_result}, {24'b0, e.res});
            chk("out_err", {31'b0, bus.out_err}, {31'b0, e.err});
            chk("latency", cyc, e.acc + 2);
            held_res = e.res;
            held_err = e.err;
          end
        end else begin
          chk("out_result_hold", {24'b0, bus.out_result}, {24'b0, held_res});
          chk("out_err_hold", {31'b0, bus.out_err}, {31'b0, held_err});
        end
        prev_vld = bus.out_valid;
      end
    end
  end

  // Called just after a negedge: waits for in_ready, presents the instruction, records expectation.
  task automatic send(logic [3:0] op, logic sgn, logic [1:0] rd, logic [1:0] rs1, logic [1:0] rs2,
                      logic [N-1:0] imm, logic hold);
    int           n;
    logic [N-1:0] r;
    logic         e;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 expected=1 (t=%0t)", $time);
    end
    bus.in_op    = op;
    bus.in_sign  = sgn;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    bus.in_valid = 1'b1;
    acc_g  = cyc + 1;
    e_a    = rf_m[rs1];
    e_b    = rf_m[rs2];
    e_op   = op;
    e_sign = sgn;
    if (op == 4'hF) begin
      r = imm;
      e = 1'b0;
    end else if (op == 4'h3 && rf_m[rs2] == '0) begin
      r = '0;
      e = 1'b1;
    end else begin
      r = alu_f(rf_m[rs1], rf_m[rs2], op, sgn);
      e = 1'b0;
    end
    if (!e) rf_m[rd] = r;
    q.push_back('{res: r, err: e, acc: acc_g});
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  // Full issue: send, then check EXEC operands and in_ready low for the two busy cycles.
  task automatic issue(logic [3:0] op, logic sgn, logic [1:0] rd, logic [1:0] rs1, logic [1:0] rs2,
                       logic [N-1:0] imm, logic hold);
    send(op, sgn, rd, rs1, rs2, imm, hold);
    @(negedge clk);
    chk("exec_alu_a", {24'b0, bus.alu_a}, {24'b0, e_a});
    chk("exec_alu_b", {24'b0, bus.alu_b}, {24'b0, e_b});
    chk("exec_alu_op", {28'b0, bus.alu_op}, {28'b0, e_op});
    chk("exec_alu_sign", {31'b0, bus.alu_sign}, {31'b0, e_sign});
    chk("exec_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(negedge clk);
    chk("wb_in_ready", {31'b0, bus.in_ready}, 32'd0);
    #1;
  endtask

  task automatic gap(int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk_dbg();
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = i[1:0];
      #1;
      chk("dbg_data", {24'b0, bus.dbg_data}, {24'b0, rf_m[i]});
    end
  endtask

  // Reset while an add is in EXEC (when_wb=0) or in WB (when_wb=1).
  task automatic reset_mid(logic when_wb);
    send(4'h0, 1'b0, 2'd1, 2'd1, 2'd1, '0, 1'b0);
    @(negedge clk);
    if (when_wb) @(negedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    for (int i = 0; i < 4; i++) rf_m[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", {31'b0, bus.in_ready}, 32'd1);
    #1;
    chk_dbg();
    gap(3);
  endtask

  initial begin
    int a0;
    int a1;
    int a2;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_sign  = 1'b0;
    bus.in_rd    = '0;
    bus.in_rs1   = '0;
    bus.in_rs2   = '0;
    bus.in_imm   = '0;
    bus.dbg_addr = '0;
    for (int i = 0; i < 4; i++) rf_m[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_alu_a", {24'b0, bus.alu_a}, 32'd0);
    chk("rst_alu_b", {24'b0, bus.alu_b}, 32'd0);
    chk("rst_alu_op", {28'b0, bus.alu_op}, 32'd0);
    chk("rst_alu_sign", {31'b0, bus.alu_sign}, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_result", {24'b0, bus.out_result}, 32'd0);
    chk("rst_out_err", {31'b0, bus.out_err}, 32'd0);
    #1;
    chk_dbg();

    // Load immediates r1=5, r2=3.
    issue(4'hF, 1'b0, 2'd1, 2'd0, 2'd0, 8'h05, 1'b0);
    issue(4'hF, 1'b0, 2'd2, 2'd0, 2'd0, 8'h03, 1'b0);
    gap(2);
    chk_dbg();

    // Signed subtract r3 = r2 - r1 = 3 - 5 = 8'hFE.
    issue(4'h1, 1'b1, 2'd3, 2'd2, 2'd1, 8'h00, 1'b0);
    gap(2);
    chk_dbg();

    // Dependent back-to-back: r0=7, then r0=r0+r0 on the first in_ready.
    issue(4'hF, 1'b0, 2'd0, 2'd0, 2'd0, 8'h07, 1'b0);
    issue(4'h0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0);
    gap(2);
    chk_dbg();

    // Divide by zero: r2=0, then r1 = r1 / r2 must leave r1 at 5.
    issue(4'hF, 1'b0, 2'd2, 2'd0, 2'd0, 8'h00, 1'b0);
    issue(4'h3, 1'b0, 2'd1, 2'd1, 2'd2, 8'h00, 1'b0);
    gap(2);
    chk_dbg();

    // Reset during EXEC and during WB.
    reset_mid(1'b0);
    reset_mid(1'b1);

    // Backpressure: three queued instructions with in_valid held high throughout.
    issue(4'hF, 1'b0, 2'd1, 2'd0, 2'd0, 8'h21, 1'b1);
    a0 = acc_g;
    issue(4'h0, 1'b0, 2'd2, 2'd1, 2'd1, 8'h00, 1'b1);
    a1 = acc_g;
    issue(4'h1, 1'b0, 2'd3, 2'd2, 2'd1, 8'h00, 1'b1);
    a2 = acc_g;
    chk("bp_spacing_1", a1 - a0, 32'd3);
    chk("bp_spacing_2", a2 - a1, 32'd3);
    gap(2);
    chk_dbg();

    // Randomized instruction stream.
    for (int k = 0; k < 60; k++) begin
      logic [3:0] op;
      case ($urandom_range(0, 6))
        0: op = 4'h0;
        1: op = 4'h1;
        2: op = 4'h2;
        3: op = 4'h3;
        4: op = 4'h4;
        5: op = 4'h5;
        default: op = 4'hF;
      endcase
      issue(op, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        gap(2);
        chk_dbg();
      end
    end
    gap(2);

    // Drain: every expectation must have been consumed.
    for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge clk);
    chk("drain_empty", q.size(), 32'd0);
    chk_dbg();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencing stage directly upstream of the combinational ALU. It accepts one instruction at a time over a valid/ready handshake and reads two operands from an internal 4-entry register file.
- It drives the ALU's a/b/operation/sign inputs, captures the ALU result and writes it back to the register file.
- It reports completion, the result and a divide-by-zero error flag.

Parameters:
- N, 8, datapath width; must match the ALU's N.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  block can accept an instruction.
- in_op  input  4  ALU operation code; 4'b1111 = load immediate, handled locally.
- in_sign  input  1  signed-mode select, forwarded to the ALU.
- in_rd  input  2  destination register index.
- in_rs1  input  2  source register index for operand a.
- in_rs2  input  2  source register index for operand b.
- in_imm  input  N  immediate value, used only by op 4'b1111.
- alu_a  output  N  operand a to the ALU.
- alu_b  output  N  operand b to the ALU.
- alu_op  output  4  operation to the ALU.
- alu_sign  output  1  sign mode to the ALU.
- alu_result  input  N  combinational result from the ALU.
- out_valid  output  1  one-cycle completion pulse.
- out_result  output  N  value written back; held until the next completion.
- out_err  output  1  valid with out_valid; 1 = divide by zero, write suppressed.
- dbg_addr  input  2  debug register-file read index.
- dbg_data  output  N  combinational read of rf[dbg_addr].

Behaviour:
- States: IDLE, EXEC, WB. in_ready = 1 only in IDLE.
- Reset (rst=1 at a clock edge) produces:
  - state=IDLE;
  - rf[0..3]=0;
  - alu_a=alu_b=0, alu_op=0, alu_sign=0;
  - out_valid=0, out_result=0, out_err=0;
  - latched instruction fields cleared.
- Reset takes priority over every other event, including reset mid-EXEC or mid-WB: the instruction is dropped, no write-back occurs and no out_valid is issued.
- IDLE, on in_valid & in_ready:
  - latch op, sign, rd and imm;
  - register alu_a<=rf[in_rs1], alu_b<=rf[in_rs2], alu_op<=in_op, alu_sign<=in_sign;
  - go to EXEC.
  - in_valid=0: stay in IDLE, hold all outputs.
- EXEC (exactly one cycle):
  - the ALU output settles combinationally;
  - at the clock edge, capture res <= (op==4'b1111) ? imm : alu_result;
  - capture err <= (op==4'b0011) & (alu_b==0);
  - go to WB.
- WB (one cycle):
  - if err=0, write rf[rd] <= res;
  - out_valid=1 for this cycle only, with out_result=res and out_err=err;
  - if err=1, rf is unchanged and out_result=0;
  - go to IDLE.
- alu_* outputs hold their values after WB until the next accept.
- out_result and out_err hold after the pulse; out_valid returns to 0.
- Timing:
  - Latency: accept at edge k → out_valid high in the cycle after edge k+2.
  - Throughput: one instruction per 3 cycles.
  - in_valid asserted during EXEC or WB is ignored (in_ready=0), so the upstream source must hold it.
- Hazards: rs1, rs2 and rd may alias. Operands are read at accept, after any prior WB write has committed, so back-to-back dependent instructions observe the prior result with no forwarding logic.
- Widths: all register values are N bits. The ALU defines overflow, truncation and shift behaviour; this block performs no arithmetic except the zero compare.
- dbg_data is a pure combinational read and reflects a WB write from the cycle after the write edge.

Test Plan:
- Reset, then ldi: with N=8, ldi r1=5 (op 1111, imm 8'h05), then ldi r2=3. Expect out_valid pulses with out_result 5 and then 3, err=0, dbg r1=5 and dbg r2=3, and in_ready low for exactly 2 cycles after each accept.
- Signed subtract: op 0001, sign=1, rd=r3, rs1=r2(3), rs2=r1(5). Expect alu_a=3 and alu_b=5 in EXEC, out_result=8'hFE, rf[3]=8'hFE.
- Dependent back-to-back: ldi r0=7, then add r0=r0+r0 issued on the first in_ready after completion. Expect out_result=14 (8'h0E); a stale operand is a failure.
- Divide by zero: rf[2]=0, op 0011, rs1=r1, rs2=r2, rd=r1. Expect out_valid=1, out_err=1, out_result=0, rf[1] unchanged at 5.
- Reset mid-operation: accept add r1=r1+r1, assert rst during EXEC. Expect no out_valid, all rf=0, in_ready=1 the cycle after reset deasserts.
- Backpressure: hold in_valid high continuously with 3 instructions queued by the source. Expect exactly one accept per 3 cycles, and each instruction executed exactly once in order.
